tif_serial_datapath: RTL

Datapath companion to the three-wire interface control FSM.
- Generates the free-running 0..FRAME_LEN-1 cycle counter (count40) that the FSM sequences on.
- Serialises the pending command onto the DQ pin during write phases.
- Deserialises the read phases into a parallel word with a one-cycle valid strobe.
- Consumes the FSM's trst, dq_en and sr_en; produces count40 back to it and rd_data/rd_valid to the host side.

---
 rtl/tif_serial_datapath_if.sv | 42 ++++
 rtl/tif_serial_datapath.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tif_serial_datapath_if.sv
// Bundles the datapath's host/FSM-facing signals and its debug taps.
// master = FSM/host side driving the datapath, slave = the datapath itself.
interface tif_serial_datapath_if #(
  parameter int CMD_BITS = 8,
  parameter int RD_BITS  = 9
);
  localparam int TXW = $clog2(CMD_BITS + 1);
  localparam int RXW = $clog2(RD_BITS + 1);

  logic                cnt_en;
  logic [CMD_BITS-1:0] cmd_wdata;
  logic                cmd_we;
  logic                trst;
  logic                dq_en;
  logic                sr_en;
  logic                dq_in;
  logic [5:0]          count40;
  logic                dq_out;
  logic                dq_oe;
  // rd_valid qualifies rd_data for exactly one cycle and has no ready:
  // the consumer must take rd_data in the cycle rd_valid is high.
  logic [RD_BITS-1:0]  rd_data;
  logic                rd_valid;
  logic                rd_ovf;

  logic [CMD_BITS-1:0] dbg_cmd_hold;
  logic [CMD_BITS-1:0] dbg_cmd_sr;
  logic [TXW-1:0]      dbg_tx_cnt;
  logic [RXW-1:0]      dbg_rx_cnt;

  modport master (
    output cnt_en, cmd_wdata, cmd_we, trst, dq_en, sr_en, dq_in,
    input  count40, dq_out, dq_oe, rd_data, rd_valid, rd_ovf,
    input  dbg_cmd_hold, dbg_cmd_sr, dbg_tx_cnt, dbg_rx_cnt
  );

  modport slave (
    input  cnt_en, cmd_wdata, cmd_we, trst, dq_en, sr_en, dq_in,
    output count40, dq_out, dq_oe, rd_data, rd_valid, rd_ovf,
    output dbg_cmd_hold, dbg_cmd_sr, dbg_tx_cnt, dbg_rx_cnt
  );
endinterface

// File: rtl/tif_serial_datapath.sv
// Three-wire interface datapath: frame counter, LSB-first command serialiser
// and LSB-first read deserialiser, sequenced by the external control FSM.
module tif_serial_datapath #(
  parameter int                  FRAME_LEN = 40,
  parameter int                  CMD_BITS  = 8,
  parameter int                  RD_BITS   = 9,
  parameter logic [CMD_BITS-1:0] CMD_RESET = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tif_serial_datapath_if.slave bus
);
  localparam int TXW = $clog2(CMD_BITS + 1);
  localparam int RXW = $clog2(RD_BITS + 1);
  localparam logic [TXW-1:0] TX_FULL = TXW'(CMD_BITS);
  localparam logic [RXW-1:0] RX_FULL = RXW'(RD_BITS);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RD_BITS - 1);
  localparam logic [5:0]     CNT_MAX = 6'(FRAME_LEN - 1);

  logic [5:0]          count40;
  logic [CMD_BITS-1:0] cmd_hold;
  logic [CMD_BITS-1:0] cmd_sr;
  logic [TXW-1:0]      tx_cnt;
  logic [RD_BITS-1:0]  rx_sr;
  logic [RXW-1:0]      rx_cnt;
  logic [RD_BITS-1:0]  rd_data;
  logic                rd_valid;
  logic                rd_ovf;

  logic                load;
  logic                tx_fire;
  logic                rx_strobe;
  logic                rx_fire;
  logic                rx_done;
  logic                rx_extra;
  logic [CMD_BITS-1:0] load_val;
  logic [RD_BITS-1:0]  rx_next;

  // Load (trst low) outranks every shift/capture strobe.
  always_comb begin
    load      = !bus.trst;
    tx_fire   = bus.trst && bus.dq_en && bus.sr_en && (tx_cnt < TX_FULL);
    rx_strobe = bus.trst && !bus.dq_en && bus.sr_en;
    rx_fire   = rx_strobe && (rx_cnt < RX_FULL);
    rx_done   = rx_fire && (rx_cnt == RX_LAST);
    rx_extra  = rx_strobe && (rx_cnt == RX_FULL);
    load_val  = bus.cmd_we ? bus.cmd_wdata : cmd_hold;
    rx_next   = {bus.dq_in, rx_sr[RD_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count40 <= '0;
    end else if (bus.cnt_en) begin
      count40 <= (count40 == CNT_MAX) ? 6'd0 : count40 + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_hold <= CMD_RESET;
    end else if (bus.cmd_we) begin
      cmd_hold <= bus.cmd_wdata;
    end
  end

  // Zero-filling shift leaves cmd_sr at 0 once all bits are out, so DQ idles low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sr <= '0;
      tx_cnt <= '0;
    end else if (load) begin
      cmd_sr <= load_val;
      tx_cnt <= '0;
    end else if (tx_fire) begin
      cmd_sr <= {1'b0, cmd_sr[CMD_BITS-1:1]};
      tx_cnt <= tx_cnt + TXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (load) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (rx_fire) begin
      rx_sr  <= rx_next;
      rx_cnt <= rx_cnt + RXW'(1);
    end
  end

  // The word is published on the same edge that captures its last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= rx_done;
      if (rx_done) begin
        rd_data <= rx_next;
      end
      if (rx_extra) begin
        rd_ovf <= 1'b1;
      end
    end
  end

  assign bus.count40      = count40;
  assign bus.dq_out       = cmd_sr[0];
  assign bus.dq_oe        = bus.dq_en;
  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_ovf       = rd_ovf;
  assign bus.dbg_cmd_hold = cmd_hold;
  assign bus.dbg_cmd_sr   = cmd_sr;
  assign bus.dbg_tx_cnt   = tx_cnt;
  assign bus.dbg_rx_cnt   = rx_cnt;
endmodule
